// File: rtl/event_encoder_pkg.sv
// Shared constants and helpers for the event encoder.
package event_encoder_pkg;

  localparam int N_EVT  = 8;
  localparam int CODE_W = 3;

  typedef logic [N_EVT-1:0]  evt_vec_t;
  typedef logic [CODE_W-1:0] code_t;

  // One-hot mask for an event index.
  function automatic evt_vec_t idx_mask(input code_t idx);
    evt_vec_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/event_encoder_prio_sel.sv
// Circular priority selector: first set bit of the pending vector,
// searching upward from a start index and wrapping at the top.
module prio_sel
  import event_encoder_pkg::*;
(
  input  logic [N_EVT-1:0]  pend,
  input  logic [CODE_W-1:0] start,
  output logic              found,
  output logic [CODE_W-1:0] index
);

  // Walk the vector starting at 'start'; the 3-bit sum wraps 7 -> 0.
  always_comb begin
    logic [CODE_W-1:0] idx;
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = 0; k < N_EVT; k++) begin
      idx = start + CODE_W'(k);
      if (!found && pend[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Event encoder: collects single-cycle event pulses into a pending vector
// and presents them one at a time as binary codes on a valid/ready port.
//
// Handshake: code/code_valid are registered. A code is transferred on a
// rising edge where code_valid=1 and code_ready=1. While code_valid=1 and
// code_ready=0 both code and code_valid hold. The slot refills on the same
// edge that it is accepted, so a consumer holding code_ready high receives
// one code per cycle.
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_EVT-1:0]  evt,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_EVT-1:0]  pending,
  output logic              overflow,
  input  logic              ovf_clr
);

  logic [CODE_W-1:0] last_idx;
  logic [CODE_W-1:0] sel_start;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_found;
  logic              slot_free;
  logic              load;
  logic [N_EVT-1:0]  load_mask;
  logic              ovf_set;

  // Round-robin resumes after the last loaded index; fixed priority starts at 0.
  assign sel_start = (RR != 0) ? last_idx + CODE_W'(1) : '0;

  prio_sel u_prio_sel (
    .pend  (pending),
    .start (sel_start),
    .found (sel_found),
    .index (sel_idx)
  );

  // Load decision and lost-event detection.
  always_comb begin
    slot_free = !code_valid || code_ready;
    load      = slot_free && sel_found;
    load_mask = load ? idx_mask(sel_idx) : '0;
    // A repeat event is lost only if its bit is still pending after this edge.
    ovf_set   = |(evt & pending & ~load_mask);
  end

  // Pending vector: new events set bits; loading clears the selected bit,
  // with a simultaneous new event for that bit winning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~load_mask) | evt;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code       <= '0;
      code_valid <= 1'b0;
      last_idx   <= CODE_W'(N_EVT - 1);
    end else if (slot_free) begin
      if (sel_found) begin
        code       <= sel_idx;
        code_valid <= 1'b1;
        last_idx   <= sel_idx;
      end else begin
        code_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow; a new overflow on the clear edge keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench for event_encoder: a fixed-priority and a round-robin
// instance share the stimulus; each phase checks the relevant instance.
module tb_event_encoder;
  import event_encoder_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [N_EVT-1:0]  evt;
  logic              code_ready;
  logic              ovf_clr;

  logic [CODE_W-1:0] code_a, code_b;
  logic              valid_a, valid_b;
  logic [N_EVT-1:0]  pend_a, pend_b;
  logic              ovf_a, ovf_b;

  int n_checks;
  int n_errors;

  event_encoder #(.RR(0)) dut_fixed (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt        (evt),
    .code       (code_a),
    .code_valid (valid_a),
    .code_ready (code_ready),
    .pending    (pend_a),
    .overflow   (ovf_a),
    .ovf_clr    (ovf_clr)
  );

  event_encoder #(.RR(1)) dut_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt        (evt),
    .code       (code_b),
    .code_valid (valid_b),
    .code_ready (code_ready),
    .pending    (pend_b),
    .overflow   (ovf_b),
    .ovf_clr    (ovf_clr)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input logic [2:0] c);
    check({tag, "_valid"}, {7'd0, valid_a}, {7'd0, v});
    if (v) check({tag, "_code"}, {5'd0, code_a}, {5'd0, c});
  endtask

  task automatic check_b(input string tag, input logic v, input logic [2:0] c);
    check({tag, "_valid"}, {7'd0, valid_b}, {7'd0, v});
    if (v) check({tag, "_code"}, {5'd0, code_b}, {5'd0, c});
  endtask

  // Reset pulse aligned away from the clock edge.
  task automatic do_reset();
    evt = '0; code_ready = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    evt = '0; code_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
    #2;
    // Reset state
    check("rst_pend",  pend_a, 8'h00);
    check("rst_valid", {7'd0, valid_a}, 8'h00);
    check("rst_code",  {5'd0, code_a}, 8'h00);
    check("rst_ovf",   {7'd0, ovf_a}, 8'h00);
    check("rst_valid_rr", {7'd0, valid_b}, 8'h00);
    tick();
    rst_n = 1'b1;

    // Fixed priority drain: 2, 5, 7 then idle.
    do_reset();
    code_ready = 1'b1;
    evt = 8'hA4;
    tick(); evt = '0;
    check("fp_pend0", pend_a, 8'hA4);
    check_a("fp_lat", 1'b0, 3'd0);
    tick(); check_a("fp_c2", 1'b1, 3'd2); check("fp_pend1", pend_a, 8'hA0);
    tick(); check_a("fp_c5", 1'b1, 3'd5);
    tick(); check_a("fp_c7", 1'b1, 3'd7); check("fp_pend3", pend_a, 8'h00);
    tick(); check_a("fp_idle", 1'b0, 3'd0);

    // Round-robin: all eight in order, then 0x09 -> 0, 3.
    do_reset();
    code_ready = 1'b1;
    evt = 8'hFF;
    tick(); evt = '0;
    check("rr_pend0", pend_b, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_b("rr_all", 1'b1, 3'(i));
    end
    evt = 8'h09;
    tick(); evt = '0;
    check_b("rr_gap", 1'b0, 3'd0);
    tick(); check_b("rr_c0", 1'b1, 3'd0);
    tick(); check_b("rr_c3", 1'b1, 3'd3);
    tick(); check_b("rr_idle", 1'b0, 3'd0);
    // Last loaded is 3: 0x12 gives 4 then 1 (fixed would give 1 then 4).
    evt = 8'h12;
    tick(); evt = '0;
    tick(); check_b("rr_c4", 1'b1, 3'd4); check_a("fp_c1", 1'b1, 3'd1);
    tick(); check_b("rr_c1", 1'b1, 3'd1); check_a("fp_c4", 1'b1, 3'd4);
    tick(); check_b("rr_idle2", 1'b0, 3'd0);

    // Back-pressure hold: code 4 held while evt[1] arrives.
    do_reset();
    evt = 8'h10;
    tick(); evt = '0;
    tick(); check_a("bp_c4", 1'b1, 3'd4);
    evt = 8'h02;
    tick(); evt = '0;
    check_a("bp_hold0", 1'b1, 3'd4); check("bp_pend", pend_a, 8'h02);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_a("bp_hold", 1'b1, 3'd4);
    end
    code_ready = 1'b1;
    tick(); check_a("bp_c1", 1'b1, 3'd1);
    tick(); check_a("bp_idle", 1'b0, 3'd0);

    // Overflow: evt[3] twice with slot busy, sticky, clear loses to new overflow.
    do_reset();
    evt = 8'h01;
    tick(); evt = '0;
    tick(); check_a("ov_busy", 1'b1, 3'd0);
    evt = 8'h08;
    tick(); check("ov_first", {7'd0, ovf_a}, 8'h00);
    tick(); evt = '0;
    check("ov_set", {7'd0, ovf_a}, 8'h01);
    tick(); check("ov_sticky", {7'd0, ovf_a}, 8'h01);
    ovf_clr = 1'b1; evt = 8'h08;
    tick(); evt = '0;
    check("ov_clr_lose", {7'd0, ovf_a}, 8'h01);
    tick(); ovf_clr = 1'b0;
    check("ov_clr", {7'd0, ovf_a}, 8'h00);

    // Set wins over clear on the load edge: code 6 presented twice.
    do_reset();
    code_ready = 1'b1;
    evt = 8'h40;
    tick();
    tick(); evt = '0;
    check_a("sw_c6a", 1'b1, 3'd6);
    check("sw_pend", pend_a, 8'h40);
    check("sw_ovf", {7'd0, ovf_a}, 8'h00);
    tick(); check_a("sw_c6b", 1'b1, 3'd6); check("sw_pend2", pend_a, 8'h00);
    tick(); check_a("sw_idle", 1'b0, 3'd0);
    check("sw_ovf2", {7'd0, ovf_a}, 8'h00);

    // Reset mid-stream discards pending and presented events.
    do_reset();
    evt = 8'h31;
    tick(); evt = '0;
    tick(); check_a("mr_c0", 1'b1, 3'd0); check("mr_pend", pend_a, 8'h30);
    #2 rst_n = 1'b0;
    #1;
    check("mr_pend0", pend_a, 8'h00);
    check("mr_valid0", {7'd0, valid_a}, 8'h00);
    check("mr_code0", {5'd0, code_a}, 8'h00);
    evt = 8'hFF;
    tick(); tick();
    check("mr_nosample", pend_a, 8'h00);
    evt = '0;
    rst_n = 1'b1;
    code_ready = 1'b1;
    tick(); tick(); tick();
    check_a("mr_quiet", 1'b0, 3'd0);
    check("mr_quiet_pend", pend_a, 8'h00);
    evt = 8'h04;
    tick(); evt = '0;
    tick(); check_a("mr_new", 1'b1, 3'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
